// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module : decode_pkg
// Purpose: Shared constants and helpers for the RV32I-subset decode stage:
//          opcodes, funct3/funct7 codes, ALU operation codes, the immediate
//          format enum and the immediate generator.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package decode_pkg;

   // Major opcodes
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // funct3 codes
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SW      = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   // funct7 codes
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;
   localparam logic [3:0] ALU_SRA = 4'd8;

   typedef enum logic [2:0] {
      IMM_NONE  = 3'd0,
      IMM_I     = 3'd1,
      IMM_SHAMT = 3'd2,
      IMM_S     = 3'd3,
      IMM_B     = 3'd4
   } imm_fmt_e;

   // funct3 plus the funct7[5] "alternate" bit selects the ALU operation.
   function automatic logic [3:0] alu_op_decode(input logic [2:0] funct3,
                                                input logic       alt);
      logic [3:0] op;
      case (funct3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Sign bit is always instr[31]; shift amounts are zero-extended.
   function automatic logic [31:0] gen_imm(input logic [31:0] instr,
                                           input imm_fmt_e    fmt);
      logic [31:0] imm;
      case (fmt)
         IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
         IMM_SHAMT: imm = {27'd0, instr[24:20]};
         IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
         default:   imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module : register_file
// Purpose: 2-read / 1-write register file with x0 hardwired to zero and
//          write-before-read bypass on both read ports.
// Ports  : clk, reset            - clock, synchronous active-high reset
//          we, waddr, wdata      - write port (writes to x0 ignored)
//          raddr1/2, rdata1/2    - combinational read ports
// Rev    : 1.0  initial release
// ============================================================================
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   localparam int NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic              wr_live;

   assign wr_live = we && (waddr != '0);

   // Entry 0 is cleared on reset and never written, so it stays zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = regs[raddr1];
      rdata2 = regs[raddr2];
      if (wr_live && (waddr == raddr1)) rdata1 = wdata;
      if (wr_live && (waddr == raddr2)) rdata2 = wdata;
      if (raddr1 == '0) rdata1 = '0;
      if (raddr2 == '0) rdata2 = '0;
   end

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module : instruction_decode
// Purpose: ID stage for an RV32I subset (R-ALU, I-ALU, LW, SW, BEQ). Decodes
//          the fetched word, reads operands and registers the ID/EX bundle.
// Ports  : clk, reset                       - clock, sync active-high reset
//          if_valid, if_pc, if_instruction  - fetch output
//          stall, flush                     - hazard / branch control
//          wb_en, wb_rd, wb_data            - register write-back
//          id_*                             - registered ID/EX bundle
// Rev    : 1.0  initial release
// ============================================================================
module instruction_decode
   import decode_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_valid,
   input  logic [31:0]           if_pc,
   input  logic [31:0]           if_instruction,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  id_valid,
   output logic [31:0]           id_pc,
   output logic [REG_ADDR_W-1:0] id_rs1,
   output logic [REG_ADDR_W-1:0] id_rs2,
   output logic [REG_ADDR_W-1:0] id_rd,
   output logic [DATA_W-1:0]     id_rs1_data,
   output logic [DATA_W-1:0]     id_rs2_data,
   output logic [31:0]           id_imm,
   output logic [3:0]            id_alu_op,
   output logic                  id_alu_src,
   output logic                  id_mem_read,
   output logic                  id_mem_write,
   output logic                  id_reg_write,
   output logic                  id_branch,
   output logic                  id_illegal
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [REG_ADDR_W-1:0] rs1_f, rs2_f, rd_f;
   logic [DATA_W-1:0]     rs1_val, rs2_val;

   assign opcode = if_instruction[6:0];
   assign funct3 = if_instruction[14:12];
   assign funct7 = if_instruction[31:25];
   assign rd_f   = if_instruction[7  +: REG_ADDR_W];
   assign rs1_f  = if_instruction[15 +: REG_ADDR_W];
   assign rs2_f  = if_instruction[20 +: REG_ADDR_W];

   register_file #(
      .DATA_W (DATA_W),
      .ADDR_W (REG_ADDR_W)
   ) u_register_file (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_en),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (rs1_f),
      .raddr2 (rs2_f),
      .rdata1 (rs1_val),
      .rdata2 (rs2_val)
   );

   // ---------------------------------------------------------------- decode
   logic [3:0] dec_alu_op;
   logic       dec_alu_src, dec_mem_read, dec_mem_write;
   logic       dec_reg_write, dec_branch, dec_illegal;
   imm_fmt_e   dec_fmt;

   always_comb begin
      dec_alu_op    = ALU_ADD;
      dec_alu_src   = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_reg_write = 1'b0;
      dec_branch    = 1'b0;
      dec_illegal   = 1'b0;
      dec_fmt       = IMM_NONE;

      case (opcode)
         OPC_R: begin
            dec_alu_op    = alu_op_decode(funct3, funct7[5]);
            dec_reg_write = 1'b1;
            // ALT funct7 exists only for SUB and SRA; SLTU is unsupported.
            if (funct7 == F7_BASE)
               dec_illegal = (funct3 == F3_SLTU);
            else if (funct7 == F7_ALT)
               dec_illegal = !((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA));
            else
               dec_illegal = 1'b1;
         end
         OPC_I_ALU: begin
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            dec_fmt       = IMM_I;
            // funct7 bits are immediate bits except in shift-immediates.
            dec_alu_op    = alu_op_decode(funct3,
                                          (funct3 == F3_SRL_SRA) && funct7[5]);
            case (funct3)
               F3_SLL: begin
                  dec_fmt     = IMM_SHAMT;
                  dec_illegal = (funct7 != F7_BASE);
               end
               F3_SRL_SRA: begin
                  dec_fmt     = IMM_SHAMT;
                  dec_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
               end
               F3_SLTU: dec_illegal = 1'b1;
               default: dec_illegal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            dec_alu_src   = 1'b1;
            dec_mem_read  = 1'b1;
            dec_reg_write = 1'b1;
            dec_fmt       = IMM_I;
            dec_illegal   = (funct3 != F3_LW);
         end
         OPC_STORE: begin
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
            dec_fmt       = IMM_S;
            dec_illegal   = (funct3 != F3_SW);
         end
         OPC_BRANCH: begin
            dec_alu_op  = ALU_SUB;
            dec_branch  = 1'b1;
            dec_fmt     = IMM_B;
            dec_illegal = (funct3 != F3_BEQ);
         end
         default: dec_illegal = 1'b1;
      endcase

      if (dec_illegal) begin
         dec_alu_op    = ALU_ADD;
         dec_alu_src   = 1'b0;
         dec_mem_read  = 1'b0;
         dec_mem_write = 1'b0;
         dec_reg_write = 1'b0;
         dec_branch    = 1'b0;
         dec_fmt       = IMM_NONE;
      end

      if (rd_f == '0) dec_reg_write = 1'b0;
   end

   // ------------------------------------------------------------ ID/EX bundle
   // A bubble (flush, or empty fetch slot while not stalled) clears every field.
   logic bubble;
   assign bubble = flush || (!stall && !if_valid);

   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         id_valid     <= 1'b0;
         id_pc        <= '0;
         id_rs1       <= '0;
         id_rs2       <= '0;
         id_rd        <= '0;
         id_rs1_data  <= '0;
         id_rs2_data  <= '0;
         id_imm       <= '0;
         id_alu_op    <= '0;
         id_alu_src   <= 1'b0;
         id_mem_read  <= 1'b0;
         id_mem_write <= 1'b0;
         id_reg_write <= 1'b0;
         id_branch    <= 1'b0;
         id_illegal   <= 1'b0;
      end else if (stall) begin
         // Held bundle still picks up a write-back to its source registers.
         if (wb_en && (wb_rd != '0) && (wb_rd == id_rs1)) id_rs1_data <= wb_data;
         if (wb_en && (wb_rd != '0) && (wb_rd == id_rs2)) id_rs2_data <= wb_data;
      end else begin
         id_valid     <= 1'b1;
         id_pc        <= if_pc;
         id_rs1       <= rs1_f;
         id_rs2       <= rs2_f;
         id_rd        <= rd_f;
         id_rs1_data  <= rs1_val;
         id_rs2_data  <= rs2_val;
         id_imm       <= gen_imm(if_instruction, dec_fmt);
         id_alu_op    <= dec_alu_op;
         id_alu_src   <= dec_alu_src;
         id_mem_read  <= dec_mem_read;
         id_mem_write <= dec_mem_write;
         id_reg_write <= dec_reg_write;
         id_branch    <= dec_branch;
         id_illegal   <= dec_illegal;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module : tb_instruction_decode
// Purpose: Self-checking bench for instruction_decode. Directed scenarios
//          followed by randomized traffic, compared every cycle against a
//          behavioural reference model of the decode stage.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_instruction_decode;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_valid = 1'b0;
   logic [31:0] if_pc = '0;
   logic [31:0] if_instruction = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;

   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [3:0]  id_alu_op;
   logic        id_alu_src, id_mem_read, id_mem_write;
   logic        id_reg_write, id_branch, id_illegal;

   always #5 clk = ~clk;

   instruction_decode #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction),
      .stall          (stall),
      .flush          (flush),
      .wb_en          (wb_en),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rd          (id_rd),
      .id_rs1_data    (id_rs1_data),
      .id_rs2_data    (id_rs2_data),
      .id_imm         (id_imm),
      .id_alu_op      (id_alu_op),
      .id_alu_src     (id_alu_src),
      .id_mem_read    (id_mem_read),
      .id_mem_write   (id_mem_write),
      .id_reg_write   (id_reg_write),
      .id_branch      (id_branch),
      .id_illegal     (id_illegal)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic [3:0]  op;
      logic        src, mr, mw, rw, br, ill;
   } bundle_t;

   bundle_t     exp_b;
   logic [31:0] mregs [32];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
   endtask

   // Architectural read as seen by an instruction in ID this cycle.
   function automatic logic [31:0] ref_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_en && wb_rd == a) return wb_data;
      return mregs[a];
   endfunction

   // Reference decode written from the instruction-set rules.
   function automatic bundle_t ref_decode(input logic [31:0] ins);
      bundle_t     b;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic        ok;
      int          simm;
      b = '0;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
      ok = 1'b1;
      if (opc == 7'h33) begin
         b.rw = 1'b1;
         case ({f7, f3})
            {7'h00, 3'd0}: b.op = 4'd0;   // ADD
            {7'h20, 3'd0}: b.op = 4'd1;   // SUB
            {7'h00, 3'd7}: b.op = 4'd2;   // AND
            {7'h00, 3'd6}: b.op = 4'd3;   // OR
            {7'h00, 3'd4}: b.op = 4'd4;   // XOR
            {7'h00, 3'd2}: b.op = 4'd5;   // SLT
            {7'h00, 3'd1}: b.op = 4'd6;   // SLL
            {7'h00, 3'd5}: b.op = 4'd7;   // SRL
            {7'h20, 3'd5}: b.op = 4'd8;   // SRA
            default:       ok = 1'b0;
         endcase
      end else if (opc == 7'h13) begin
         b.rw = 1'b1; b.src = 1'b1;
         simm = $signed(ins) >>> 20;
         b.imm = simm;
         case (f3)
            3'd0: b.op = 4'd0;
            3'd2: b.op = 4'd5;
            3'd4: b.op = 4'd4;
            3'd6: b.op = 4'd3;
            3'd7: b.op = 4'd2;
            3'd1: begin b.op = 4'd6; b.imm = 32'(ins[24:20]); ok = (f7 == 7'h00); end
            3'd5: begin
               b.imm = 32'(ins[24:20]);
               if (f7 == 7'h00) b.op = 4'd7;
               else if (f7 == 7'h20) b.op = 4'd8;
               else ok = 1'b0;
            end
            default: ok = 1'b0;
         endcase
      end else if (opc == 7'h03 && f3 == 3'd2) begin
         b.src = 1'b1; b.mr = 1'b1; b.rw = 1'b1;
         simm = $signed(ins) >>> 20;
         b.imm = simm;
      end else if (opc == 7'h23 && f3 == 3'd2) begin
         b.src = 1'b1; b.mw = 1'b1;
         simm = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
         b.imm = simm;
      end else if (opc == 7'h63 && f3 == 3'd0) begin
         b.op = 4'd1; b.br = 1'b1;
         simm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
              + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         b.imm = simm;
      end else begin
         ok = 1'b0;
      end
      if (!ok) begin
         b.op = '0; b.src = 0; b.mr = 0; b.mw = 0; b.rw = 0; b.br = 0;
         b.imm = '0; b.ill = 1'b1;
      end
      if (b.rd == 5'd0) b.rw = 1'b0;
      return b;
   endfunction

   task automatic compare_all();
      check("valid",  32'(id_valid),     32'(exp_b.valid));
      check("pc",     id_pc,             exp_b.pc);
      check("rs1",    32'(id_rs1),       32'(exp_b.rs1));
      check("rs2",    32'(id_rs2),       32'(exp_b.rs2));
      check("rd",     32'(id_rd),        32'(exp_b.rd));
      check("rs1_data", id_rs1_data,     exp_b.d1);
      check("rs2_data", id_rs2_data,     exp_b.d2);
      check("imm",    id_imm,            exp_b.imm);
      check("alu_op", 32'(id_alu_op),    32'(exp_b.op));
      check("alu_src",  32'(id_alu_src),   32'(exp_b.src));
      check("mem_read", 32'(id_mem_read),  32'(exp_b.mr));
      check("mem_write",32'(id_mem_write), 32'(exp_b.mw));
      check("reg_write",32'(id_reg_write), 32'(exp_b.rw));
      check("branch",   32'(id_branch),    32'(exp_b.br));
      check("illegal",  32'(id_illegal),   32'(exp_b.ill));
   endtask

   // One clock: predict from the pre-edge inputs, then compare after the edge.
   task automatic step();
      bundle_t nxt;
      if (reset) begin
         nxt = '0;
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end else begin
         if (flush || (!stall && !if_valid)) begin
            nxt = '0;
         end else if (stall) begin
            nxt = exp_b;
            if (wb_en && wb_rd != 5'd0 && wb_rd == nxt.rs1) nxt.d1 = wb_data;
            if (wb_en && wb_rd != 5'd0 && wb_rd == nxt.rs2) nxt.d2 = wb_data;
         end else begin
            nxt       = ref_decode(if_instruction);
            nxt.valid = 1'b1;
            nxt.pc    = if_pc;
            nxt.d1    = ref_read(if_instruction[19:15]);
            nxt.d2    = ref_read(if_instruction[24:20]);
         end
         if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
      end
      @(posedge clk);
      #1;
      exp_b = nxt;
      compare_all();
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      if_valid = 1'b1; if_instruction = ins; if_pc = pc;
      step();
   endtask

   function automatic logic [4:0] rand_reg();
      return ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] r;
      r  = $urandom;
      f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 6))
         0, 1: return {f7, rand_reg(), rand_reg(), f3, rand_reg(), 7'h33};
         2:    return {($urandom_range(0, 1) != 0) ? f7 : r[31:25], r[24:20],
                       rand_reg(), f3, rand_reg(), 7'h13};
         3:    return {r[31:20], rand_reg(), ($urandom_range(0, 3) != 0) ? 3'd2 : f3,
                       rand_reg(), 7'h03};
         4:    return {r[31:25], rand_reg(), rand_reg(),
                       ($urandom_range(0, 3) != 0) ? 3'd2 : f3, r[11:7], 7'h23};
         5:    return {r[31:25], rand_reg(), rand_reg(),
                       ($urandom_range(0, 3) != 0) ? 3'd0 : f3, r[11:7], 7'h63};
         default: return r;
      endcase
   endfunction

   initial begin
      exp_b = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

      // Reset
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;

      // addi x1,x0,5
      issue(32'h00500093, 32'h0000_0100);
      check("tp_addi_valid", 32'(id_valid), 32'd1);
      check("tp_addi_imm", id_imm, 32'd5);
      check("tp_addi_src", 32'(id_alu_src), 32'd1);

      // add x3,x1,x1 while x1 is written back the same cycle
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
      issue(32'h001081B3, 32'h0000_0104);
      check("tp_bypass_rs1", id_rs1_data, 32'hDEADBEEF);
      check("tp_bypass_rs2", id_rs2_data, 32'hDEADBEEF);
      wb_en = 1'b0;

      // sw x2,12(x1) then beq x1,x2,-4
      issue(32'h0020A623, 32'h0000_0108);
      check("tp_sw_imm", id_imm, 32'd12);
      check("tp_sw_regwrite", 32'(id_reg_write), 32'd0);
      issue(32'hFE208EE3, 32'h0000_010C);
      check("tp_beq_imm", id_imm, 32'hFFFFFFFC);
      check("tp_beq_branch", 32'(id_branch), 32'd1);

      // lw x5,0(x1), then 3 stalled cycles with x1 written back
      issue(32'h0000A283, 32'h0000_0110);
      stall = 1'b1; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h11;
      if_instruction = 32'h00500093;
      for (int i = 0; i < 3; i++) step();
      check("tp_stall_rs1_data", id_rs1_data, 32'h11);
      check("tp_stall_mem_read", 32'(id_mem_read), 32'd1);
      wb_en = 1'b0; flush = 1'b1;
      step();
      check("tp_flush_valid", 32'(id_valid), 32'd0);
      flush = 1'b0; stall = 1'b0;

      // write to x0 ignored; add x3,x0,x0 reads zero
      wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
      issue(32'h000001B3, 32'h0000_0114);
      check("tp_x0_read", id_rs1_data, 32'd0);
      wb_en = 1'b0;
      issue(32'h0000007F, 32'h0000_0118);
      check("tp_illegal", 32'(id_illegal), 32'd1);

      // reset during stall with a valid bundle
      wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234_5678;
      issue(32'h00738393, 32'h0000_011C);   // addi x7,x7,7
      stall = 1'b1; reset = 1'b1;
      step();
      check("tp_reset_valid", 32'(id_valid), 32'd0);
      reset = 1'b0; stall = 1'b0; wb_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         issue({7'h00, 5'(2 * i + 1), 5'(2 * i), 3'd0, 5'd3, 7'h33}, 32'(i * 4));
         check("tp_cleared_reg", id_rs1_data | id_rs2_data, 32'd0);
      end

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         reset          = ($urandom_range(0, 99) < 2);
         stall          = ($urandom_range(0, 4) == 0);
         flush          = ($urandom_range(0, 9) == 0);
         if_valid       = ($urandom_range(0, 6) != 0);
         if_pc          = $urandom;
         if_instruction = rand_instr();
         wb_en          = ($urandom_range(0, 1) != 0);
         wb_rd          = rand_reg();
         wb_data        = $urandom;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
